// File: rtl/trax_turn_controller.sv
// trax_turn_controller
//   Turn sequencer between the Trax engine and the serial transceiver.
//   Waits for the colour assignment, then alternates between handing the
//   local move to the transceiver and delivering the opponent's move to the
//   engine. Counts completed moves (both sides, wrapping at 16 bits).
//
//   Optional feature: define TRAX_TIMEOUT_EN to enable the link watchdog.
//   When enabled, spending TIMEOUT_CYCLES cycles in SEND or REMOTE_WAIT
//   moves the block into a terminal FAULT state (left only by reset).
//
// Ports
//   clock, reset            system clock, async active-low reset
//   color, color_valid      colour from transceiver (0 white, 1 black)
//   local_move/valid/ready  engine -> controller move handshake
//   xcvr_move_in            registered move presented for transmission
//   xcvr_start_transmit     level transmit request
//   xcvr_send_done          one-cycle pulse, packet fully sent
//   xcvr_move_out           received move
//   xcvr_end_receive        level, rises when a packet is complete
//   remote_move/valid/ready controller -> engine move handshake
//   my_turn                 high while waiting for the local move
//   move_count              completed moves, both sides
//   fault                   sticky link-timeout flag
module trax_turn_controller #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd96_000_000,
    parameter int          MOVE_W         = 22
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              color,
    input  logic              color_valid,
    input  logic [MOVE_W-1:0] local_move,
    input  logic              local_valid,
    output logic              local_ready,
    output logic [MOVE_W-1:0] xcvr_move_in,
    output logic              xcvr_start_transmit,
    input  logic              xcvr_send_done,
    input  logic [MOVE_W-1:0] xcvr_move_out,
    input  logic              xcvr_end_receive,
    output logic [MOVE_W-1:0] remote_move,
    output logic              remote_valid,
    input  logic              remote_ready,
    output logic              my_turn,
    output logic [15:0]       move_count,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_WAIT_COLOR,
        S_LOCAL_WAIT,
        S_SEND,
        S_REMOTE_WAIT,
        S_DELIVER,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic              color_valid_q;
    logic              color_q, color_d;
    logic              end_q, end_prev_q;
    logic              end_rise;
    logic [MOVE_W-1:0] xmove_q, xmove_d;
    logic [MOVE_W-1:0] rmove_q, rmove_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              local_ready_q, local_ready_d;
    logic              start_q, start_d;
    logic              rvalid_q, rvalid_d;

`ifdef TRAX_TIMEOUT_EN
    logic [31:0]       tmo_q, tmo_d;
    logic              fault_q, fault_d;
`endif

    // end_q/end_prev_q form a two-stage history of xcvr_end_receive, so a
    // rise is acted on one cycle after it is first sampled. Both reset to 1:
    // a level that is already high is never mistaken for a fresh packet.
    assign end_rise = end_q & ~end_prev_q;

    always_comb begin
        state_d = state_q;
        color_d = color_q;
        xmove_d = xmove_q;
        rmove_d = rmove_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_WAIT_COLOR: begin
                // color_valid is registered first; color_q is the colour
                // sampled on the same edge as color_valid_q.
                color_d = color;
                if (color_valid_q)
                    state_d = color_q ? S_REMOTE_WAIT : S_LOCAL_WAIT;
            end
            S_LOCAL_WAIT: begin
                if (local_valid && local_ready_q) begin
                    xmove_d = local_move;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (xcvr_send_done) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_REMOTE_WAIT;
                end
            end
            S_REMOTE_WAIT: begin
                if (end_rise) begin
                    rmove_d = xcvr_move_out;
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (remote_ready && rvalid_q) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_LOCAL_WAIT;
                end
            end
            default: state_d = state_q;
        endcase

`ifdef TRAX_TIMEOUT_EN
        tmo_d = tmo_q;
        if (state_q == S_SEND || state_q == S_REMOTE_WAIT) begin
            tmo_d = tmo_q + 32'd1;
            // Timeout wins over a completion arriving on the same cycle.
            if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                state_d = S_FAULT;
                cnt_d   = cnt_q;
                rmove_d = rmove_q;
            end
        end
        if (state_d != state_q &&
            (state_d == S_SEND || state_d == S_REMOTE_WAIT))
            tmo_d = '0;
        fault_d = (state_d == S_FAULT);
`endif

        // Outputs are registered from the next state so they change on the
        // same edge as the transition.
        local_ready_d = (state_d == S_LOCAL_WAIT);
        start_d       = (state_d == S_SEND);
        rvalid_d      = (state_d == S_DELIVER);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_WAIT_COLOR;
            color_valid_q <= 1'b0;
            color_q       <= 1'b0;
            end_q         <= 1'b1;
            end_prev_q    <= 1'b1;
            xmove_q       <= '0;
            rmove_q       <= '0;
            cnt_q         <= '0;
            local_ready_q <= 1'b0;
            start_q       <= 1'b0;
            rvalid_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            color_valid_q <= color_valid;
            color_q       <= color_d;
            end_q         <= xcvr_end_receive;
            end_prev_q    <= end_q;
            xmove_q       <= xmove_d;
            rmove_q       <= rmove_d;
            cnt_q         <= cnt_d;
            local_ready_q <= local_ready_d;
            start_q       <= start_d;
            rvalid_q      <= rvalid_d;
        end
    end

`ifdef TRAX_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign local_ready         = local_ready_q;
    assign my_turn             = local_ready_q;
    assign xcvr_move_in        = xmove_q;
    assign xcvr_start_transmit = start_q;
    assign remote_move         = rmove_q;
    assign remote_valid        = rvalid_q;
    assign move_count          = cnt_q;

endmodule

// File: tb/tb_trax_turn_controller.sv
// Bench for trax_turn_controller: vector table, hand-written corner
// sequences (async reset mid-send, counter wrap, optional timeout) and a
// randomized run checked against a turn-level reference model.
module tb_trax_turn_controller;

    logic        clock;
    logic        reset;
    logic        color, color_valid;
    logic [21:0] local_move;
    logic        local_valid, local_ready;
    logic [21:0] xcvr_move_in;
    logic        xcvr_start_transmit, xcvr_send_done;
    logic [21:0] xcvr_move_out;
    logic        xcvr_end_receive;
    logic [21:0] remote_move;
    logic        remote_valid, remote_ready;
    logic        my_turn;
    logic [15:0] move_count;
    logic        fault;

    int checks = 0;
    int errors = 0;

    trax_turn_controller #(.TIMEOUT_CYCLES(32'd100), .MOVE_W(22)) dut (
        .clock(clock), .reset(reset),
        .color(color), .color_valid(color_valid),
        .local_move(local_move), .local_valid(local_valid), .local_ready(local_ready),
        .xcvr_move_in(xcvr_move_in), .xcvr_start_transmit(xcvr_start_transmit),
        .xcvr_send_done(xcvr_send_done), .xcvr_move_out(xcvr_move_out),
        .xcvr_end_receive(xcvr_end_receive),
        .remote_move(remote_move), .remote_valid(remote_valid), .remote_ready(remote_ready),
        .my_turn(my_turn), .move_count(move_count), .fault(fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Observation vector: {local_ready, my_turn, start, remote_valid, fault,
    //                      move_count, xcvr_move_in, remote_move}
    function automatic logic [64:0] obs();
        return {local_ready, my_turn, xcvr_start_transmit, remote_valid, fault,
                move_count, xcvr_move_in, remote_move};
    endfunction

    function automatic logic [64:0] ex(input logic lr, input logic st, input logic rv,
                                       input logic [15:0] c, input logic [21:0] xi,
                                       input logic [21:0] rm);
        return {lr, lr, st, rv, 1'b0, c, xi, rm};
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic zero_inputs();
        color = 0; color_valid = 0; local_move = '0; local_valid = 0;
        xcvr_send_done = 0; xcvr_move_out = '0; xcvr_end_receive = 0; remote_ready = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    // ctl bits: {rst_before, color_valid, color, local_valid, send_done, end_receive, remote_ready}
    // exp bits: {local_ready(=my_turn), start_transmit, remote_valid}
    typedef struct {
        logic [6:0]  ctl;
        logic [21:0] lm;
        logic [21:0] mo;
        logic [2:0]  exp_f;
        logic [15:0] cnt;
        logic [21:0] xin;
        logic [21:0] rm;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t v(input logic [6:0] ctl, input logic [21:0] lm, input logic [21:0] mo,
                               input logic [2:0] ef, input logic [15:0] c,
                               input logic [21:0] xi, input logic [21:0] rm);
        vec_t r;
        r.ctl = ctl; r.lm = lm; r.mo = mo; r.exp_f = ef; r.cnt = c; r.xin = xi; r.rm = rm;
        return r;
    endfunction

    // ---------------- reference model ----------------
    localparam int PH_COLOR = 0, PH_LOCAL = 1, PH_SEND = 2, PH_REMOTE = 3, PH_DELIVER = 4;
    int          m_ph;
    logic        m_cv_prev, m_col_prev;
    logic        m_er_hist1, m_er_hist2;   // end_receive one / two edges ago
    logic [15:0] m_cnt;
    logic [21:0] m_xin, m_rm;

    task automatic model_reset();
        m_ph = PH_COLOR; m_cv_prev = 0; m_col_prev = 0;
        m_er_hist1 = 1; m_er_hist2 = 1;
        m_cnt = 0; m_xin = 0; m_rm = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        case (m_ph)
            PH_COLOR:   if (m_cv_prev) m_ph = m_col_prev ? PH_REMOTE : PH_LOCAL;
            PH_LOCAL:   if (local_valid) begin m_xin = local_move; m_ph = PH_SEND; end
            PH_SEND:    if (xcvr_send_done) begin m_cnt = m_cnt + 16'd1; m_ph = PH_REMOTE; end
            PH_REMOTE:  if (m_er_hist1 && !m_er_hist2) begin m_rm = xcvr_move_out; m_ph = PH_DELIVER; end
            PH_DELIVER: if (remote_ready) begin m_cnt = m_cnt + 16'd1; m_ph = PH_LOCAL; end
            default: ;
        endcase
        m_er_hist2 = m_er_hist1;
        m_er_hist1 = xcvr_end_receive;
        m_cv_prev  = color_valid;
        m_col_prev = color;
    endtask

    function automatic logic [64:0] model_obs();
        return ex(m_ph == PH_LOCAL, m_ph == PH_SEND, m_ph == PH_DELIVER, m_cnt, m_xin, m_rm);
    endfunction

    initial begin
        // White game, out-of-turn inputs, already-high end_receive.
        tbl[0]  = v(7'b0100000, 22'h0,      22'h0,      3'b000, 16'd0, 22'h0,     22'h0);
        tbl[1]  = v(7'b0100000, 22'h0,      22'h0,      3'b100, 16'd0, 22'h0,     22'h0);
        tbl[2]  = v(7'b0101000, 22'h00401,  22'h0,      3'b010, 16'd0, 22'h00401, 22'h0);
        tbl[3]  = v(7'b0110000, 22'h0,      22'h0,      3'b010, 16'd0, 22'h00401, 22'h0);
        tbl[4]  = v(7'b0110100, 22'h0,      22'h0,      3'b000, 16'd1, 22'h00401, 22'h0);
        tbl[5]  = v(7'b0101001, 22'h3FFFFF, 22'h0,      3'b000, 16'd1, 22'h00401, 22'h0);
        tbl[6]  = v(7'b0100010, 22'h0,      22'h20C03,  3'b000, 16'd1, 22'h00401, 22'h0);
        tbl[7]  = v(7'b0100010, 22'h0,      22'h20C03,  3'b001, 16'd1, 22'h00401, 22'h20C03);
        tbl[8]  = v(7'b0100011, 22'h0,      22'h0,      3'b100, 16'd2, 22'h00401, 22'h20C03);
        tbl[9]  = v(7'b0101010, 22'h12345,  22'h0,      3'b010, 16'd2, 22'h12345, 22'h20C03);
        tbl[10] = v(7'b0100110, 22'h0,      22'h0,      3'b000, 16'd3, 22'h12345, 22'h20C03);
        tbl[11] = v(7'b0100110, 22'h0,      22'h0,      3'b000, 16'd3, 22'h12345, 22'h20C03);
        tbl[12] = v(7'b0100000, 22'h0,      22'h0,      3'b000, 16'd3, 22'h12345, 22'h20C03);
        tbl[13] = v(7'b0100010, 22'h0,      22'h000AA,  3'b000, 16'd3, 22'h12345, 22'h20C03);
        tbl[14] = v(7'b0100010, 22'h0,      22'h000AA,  3'b001, 16'd3, 22'h12345, 22'h000AA);
        tbl[15] = v(7'b0100011, 22'h0,      22'h0,      3'b100, 16'd4, 22'h12345, 22'h000AA);
        // Black game after reset; colour change after assignment is ignored.
        tbl[16] = v(7'b1110000, 22'h0,      22'h0,      3'b000, 16'd0, 22'h0,     22'h0);
        tbl[17] = v(7'b0100000, 22'h0,      22'h0,      3'b000, 16'd0, 22'h0,     22'h0);
        tbl[18] = v(7'b0100010, 22'h0,      22'h10802,  3'b000, 16'd0, 22'h0,     22'h0);
        tbl[19] = v(7'b0100010, 22'h0,      22'h10802,  3'b001, 16'd0, 22'h0,     22'h10802);
        tbl[20] = v(7'b0100011, 22'h0,      22'h0,      3'b100, 16'd1, 22'h0,     22'h10802);
        tbl[21] = v(7'b0101010, 22'h00C0C,  22'h0,      3'b010, 16'd1, 22'h00C0C, 22'h10802);

        zero_inputs();
        reset = 1'b0;
        #12;
        chk("reset_state_held", obs(), 65'h0);
        do_reset();
        chk("reset_state", obs(), 65'h0);

        foreach (tbl[i]) begin
            if (tbl[i].ctl[6]) do_reset();
            {color_valid, color, local_valid, xcvr_send_done, xcvr_end_receive, remote_ready} = tbl[i].ctl[5:0];
            local_move    = tbl[i].lm;
            xcvr_move_out = tbl[i].mo;
            cyc();
            chk($sformatf("vec%0d", i), obs(),
                ex(tbl[i].exp_f[2], tbl[i].exp_f[1], tbl[i].exp_f[0], tbl[i].cnt, tbl[i].xin, tbl[i].rm));
        end

        // ---- reset mid-SEND: transmit request drops asynchronously ----
        do_reset();
        color_valid = 1; cyc(); cyc();
        local_valid = 1; local_move = 22'h0_0401; cyc();
        local_valid = 0; xcvr_send_done = 1; cyc();
        xcvr_send_done = 0; xcvr_end_receive = 1; cyc(); cyc();
        remote_ready = 1; cyc();
        remote_ready = 0; local_valid = 1; local_move = 22'h2_1111; cyc();
        local_valid = 0;
        chk("pre_reset_send", obs(), ex(1'b0, 1'b1, 1'b0, 16'd2, 22'h2_1111, 22'h0));
        #2 reset = 1'b0;
        #1 chk("async_reset_drop", obs(), 65'h0);
        zero_inputs();
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_reset_idle", obs(), 65'h0);
        color_valid = 1; cyc();
        chk("post_reset_wait", obs(), 65'h0);
        cyc();
        chk("post_reset_white", obs(), ex(1'b1, 1'b0, 1'b0, 16'd0, 22'h0, 22'h0));

        // ---- counter wrap: preload 65534 completed moves, then two more ----
        force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
        color_valid = 0; cyc();
        local_valid = 1; local_move = 22'h0_0003; cyc();
        local_valid = 0; xcvr_send_done = 1; cyc();
        chk("wrap_ffff", {49'h0, move_count}, 65'h0FFFF);
        xcvr_send_done = 0; xcvr_end_receive = 1; xcvr_move_out = 22'h0_0005; cyc(); cyc();
        remote_ready = 1; cyc();
        remote_ready = 0;
        chk("wrap_zero", obs(), ex(1'b1, 1'b0, 1'b0, 16'd0, 22'h0_0003, 22'h0_0005));

`ifdef TRAX_TIMEOUT_EN
        // ---- watchdog in REMOTE_WAIT ----
        do_reset();
        color_valid = 1; color = 1; cyc(); cyc();   // now in REMOTE_WAIT
        for (int k = 0; k < 99; k++) cyc();
        chk("timeout_not_yet", {64'h0, fault}, 65'h0);
        cyc();
        chk("timeout_fault", {64'h0, fault}, 65'h1);
        xcvr_end_receive = 1; cyc(); cyc(); cyc();
        chk("timeout_terminal", {63'h0, fault, remote_valid}, 65'h2);
`endif

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                model_reset();
            end
            color_valid    = ($urandom_range(0, 3) != 0);
            color          = 1'($urandom);
            local_valid    = 1'($urandom);
            local_move     = 22'($urandom);
            xcvr_send_done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) xcvr_end_receive = ~xcvr_end_receive;
            xcvr_move_out  = 22'($urandom);
            remote_ready   = 1'($urandom);
            model_step();
            cyc();
            chk($sformatf("rand%0d", n), obs(), model_obs());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
